// File: rtl/rr_sel_pkg.sv
// Shared definitions for the rr_sel_arb round-robin arbiter slice.
//   state_t : arbiter FSM states (IDLE, GRANT, GAP)
//   NUM_CH  : number of request channels
//   IDX_W   : width of a channel index
//   CNT_W   : width of the grant-length counter
package rr_sel_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    GAP
  } state_t;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned IDX_W  = 2;
  localparam int unsigned CNT_W  = 8;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
//   req   : per-channel request vector
//   ptr   : highest-priority channel
//   found : at least one channel is requesting
//   idx   : first requesting channel in order ptr, ptr+1, ... (mod NUM_CH)
module rr_pick
  import rr_sel_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  output logic              found,
  output logic [IDX_W-1:0]  idx
);

  logic [NUM_CH-1:0] rot;
  logic [IDX_W-1:0]  k;

  always_comb begin
    rot   = '0;
    k     = '0;
    found = 1'b0;
    // Rotate so that bit 0 of rot is channel ptr.
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      rot[i] = req[ptr + IDX_W'(i)];
    end
    // Fixed-priority encode, lowest rotated position wins.
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        k     = IDX_W'(i);
      end
    end
    // Rotate the winner back into absolute channel numbering.
    idx = ptr + k;
  end

endmodule

// File: rtl/rr_sel_arb.sv
// Four-channel round-robin arbiter feeding a 2-to-4 enable decoder.
//   clk     : clock, rising edge
//   rst_n   : asynchronous active-low reset
//   req     : level-sensitive per-channel requests
//   done    : grantee releases its grant (sampled only in GRANT)
//   sel0/1  : registered granted channel index (decoder in0/in1)
//   en      : registered grant valid (decoder en)
//   timeout : one-cycle pulse in GAP when the hold limit alone ended the grant
// Grants last 1..HOLD_MAX cycles and are followed by one GAP cycle and one
// IDLE cycle, so en is low for at least two cycles between grants.
module rr_sel_arb
  import rr_sel_pkg::*;
#(
  parameter int unsigned HOLD_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] req,
  input  logic              done,
  output logic              sel0,
  output logic              sel1,
  output logic              en,
  output logic              timeout
);

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] sel_r;
  logic [CNT_W-1:0] cnt;
  logic             en_r;
  logic             timeout_r;

  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;

  logic             at_limit;
  logic             req_live;
  logic             rel;
  logic             limit_only;

  rr_pick u_pick (
    .req   (req),
    .ptr   (ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    at_limit   = (cnt == CNT_W'(HOLD_MAX));
    req_live   = req[sel_r];
    rel        = done || !req_live || at_limit;
    // A release is a timeout only if nothing else also asked for it.
    limit_only = at_limit && !done && req_live;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      cnt       <= '0;
      sel_r     <= '0;
      en_r      <= 1'b0;
      timeout_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          timeout_r <= 1'b0;
          if (pick_found) begin
            sel_r <= pick_idx;
            cnt   <= CNT_W'(1);
            en_r  <= 1'b1;
            state <= GRANT;
          end
        end
        GRANT: begin
          if (rel) begin
            ptr       <= sel_r + IDX_W'(1);
            en_r      <= 1'b0;
            timeout_r <= limit_only;
            state     <= GAP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        GAP: begin
          timeout_r <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          en_r      <= 1'b0;
          timeout_r <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  assign sel0    = sel_r[0];
  assign sel1    = sel_r[1];
  assign en      = en_r;
  assign timeout = timeout_r;

endmodule

// File: tb/tb_rr_sel_arb.sv
// Self-checking bench for rr_sel_arb: constant vector table for the directed
// scenarios, a behavioural grant model checked on every cycle, hand-written
// async-reset sequence and a randomized run.
module tb_rr_sel_arb;

  localparam int HOLD = 4;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic       sel0, sel1, en, timeout;

  rr_sel_arb #(.HOLD_MAX(HOLD)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .done    (done),
    .sel0    (sel0),
    .sel1    (sel1),
    .en      (en),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: a grant is "busy" for len cycles, then one gap cycle.
  bit m_busy;
  bit m_gap;
  int m_len;
  int m_ptr;
  int m_sel;
  bit m_to;

  task automatic model_reset();
    m_busy = 0; m_gap = 0; m_len = 0; m_ptr = 0; m_sel = 0; m_to = 0;
  endtask

  task automatic model_edge(input logic [3:0] r, input logic d);
    bit rel;
    if (m_busy) begin
      rel = d || !r[m_sel] || (m_len == HOLD);
      if (rel) begin
        m_to   = (m_len == HOLD) && !d && r[m_sel];
        m_ptr  = (m_sel + 1) % 4;
        m_busy = 0;
        m_gap  = 1;
      end else begin
        m_len++;
        m_to = 0;
      end
    end else if (m_gap) begin
      m_gap = 0;
      m_to  = 0;
    end else begin
      m_to = 0;
      for (int k = 0; k < 4; k++) begin
        if (!m_busy && r[(m_ptr + k) % 4]) begin
          m_sel  = (m_ptr + k) % 4;
          m_busy = 1;
          m_len  = 1;
        end
      end
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    check("model_en", int'(en), int'(m_busy));
    check("model_timeout", int'(timeout), int'(m_to));
    check("model_sel", int'({sel1, sel0}), m_sel);
  endtask

  // Drive inputs, take one edge, sample 1 time unit later.
  task automatic step(input logic [3:0] r, input logic d);
    req  = r;
    done = d;
    @(posedge clk);
    #1;
    model_edge(r, d);
    check_model();
  endtask

  typedef struct {
    logic [3:0] req;
    logic       done;
    logic       en;
    logic [1:0] sel;
    logic       to;
  } vec_t;

  vec_t tbl[$];

  initial begin
    logic [3:0] rr;
    logic       dd;

    // Rotation with done in each grant's first cycle (ch0 granted already).
    tbl.push_back('{4'hF, 1'b1, 1'b0, 2'd0, 1'b0});
    tbl.push_back('{4'hF, 1'b0, 1'b0, 2'd0, 1'b0});
    tbl.push_back('{4'hF, 1'b0, 1'b1, 2'd1, 1'b0});
    tbl.push_back('{4'hF, 1'b1, 1'b0, 2'd1, 1'b0});
    tbl.push_back('{4'hF, 1'b0, 1'b0, 2'd1, 1'b0});
    tbl.push_back('{4'hF, 1'b0, 1'b1, 2'd2, 1'b0});
    tbl.push_back('{4'hF, 1'b1, 1'b0, 2'd2, 1'b0});
    tbl.push_back('{4'hF, 1'b0, 1'b0, 2'd2, 1'b0});
    tbl.push_back('{4'hF, 1'b0, 1'b1, 2'd3, 1'b0});
    tbl.push_back('{4'hF, 1'b1, 1'b0, 2'd3, 1'b0});
    tbl.push_back('{4'hF, 1'b0, 1'b0, 2'd3, 1'b0});
    tbl.push_back('{4'hF, 1'b0, 1'b1, 2'd0, 1'b0});
    // Timeout on channel 2: four cycles of en, then a timeout pulse.
    tbl.push_back('{4'h4, 1'b1, 1'b0, 2'd0, 1'b0});
    tbl.push_back('{4'h4, 1'b0, 1'b0, 2'd0, 1'b0});
    tbl.push_back('{4'h4, 1'b0, 1'b1, 2'd2, 1'b0});
    tbl.push_back('{4'h4, 1'b0, 1'b1, 2'd2, 1'b0});
    tbl.push_back('{4'h4, 1'b0, 1'b1, 2'd2, 1'b0});
    tbl.push_back('{4'h4, 1'b0, 1'b1, 2'd2, 1'b0});
    tbl.push_back('{4'h4, 1'b0, 1'b0, 2'd2, 1'b1});
    tbl.push_back('{4'h4, 1'b0, 1'b0, 2'd2, 1'b0});
    tbl.push_back('{4'h4, 1'b0, 1'b1, 2'd2, 1'b0});
    // Coincident done at the hold limit: no timeout.
    tbl.push_back('{4'h4, 1'b0, 1'b1, 2'd2, 1'b0});
    tbl.push_back('{4'h4, 1'b0, 1'b1, 2'd2, 1'b0});
    tbl.push_back('{4'h4, 1'b0, 1'b1, 2'd2, 1'b0});
    tbl.push_back('{4'h4, 1'b1, 1'b0, 2'd2, 1'b0});
    tbl.push_back('{4'h0, 1'b0, 1'b0, 2'd2, 1'b0});
    tbl.push_back('{4'h0, 1'b0, 1'b0, 2'd2, 1'b0});
    // Request drop on channel 3; next grant from ptr 0 goes to channel 1.
    tbl.push_back('{4'h9, 1'b0, 1'b1, 2'd3, 1'b0});
    tbl.push_back('{4'h9, 1'b0, 1'b1, 2'd3, 1'b0});
    tbl.push_back('{4'h6, 1'b0, 1'b0, 2'd3, 1'b0});
    tbl.push_back('{4'h6, 1'b0, 1'b0, 2'd3, 1'b0});
    tbl.push_back('{4'h6, 1'b0, 1'b1, 2'd1, 1'b0});
    tbl.push_back('{4'h6, 1'b1, 1'b0, 2'd1, 1'b0});

    // Reset with all channels requesting.
    rst_n = 1'b0;
    req   = 4'hF;
    done  = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_en", int'(en), 0);
    check("reset_sel", int'({sel1, sel0}), 0);
    check("reset_timeout", int'(timeout), 0);
    #3 rst_n = 1'b1;
    @(negedge clk);
    check("reset_idle_en", int'(en), 0);
    @(posedge clk);
    #1;
    model_edge(4'hF, 1'b0);
    check("first_grant_en", int'(en), 1);
    check("first_grant_sel", int'({sel1, sel0}), 0);
    check_model();

    foreach (tbl[i]) begin
      step(tbl[i].req, tbl[i].done);
      check($sformatf("tbl%0d_en", i), int'(en), int'(tbl[i].en));
      check($sformatf("tbl%0d_sel", i), int'({sel1, sel0}), int'(tbl[i].sel));
      check($sformatf("tbl%0d_timeout", i), int'(timeout), int'(tbl[i].to));
    end

    // Async reset mid-grant on channel 3.
    step(4'h8, 1'b0);
    step(4'h8, 1'b0);
    check("pre_areset_en", int'(en), 1);
    check("pre_areset_sel", int'({sel1, sel0}), 3);
    #2 rst_n = 1'b0;
    #1;
    check("areset_en", int'(en), 0);
    check("areset_sel", int'({sel1, sel0}), 0);
    check("areset_timeout", int'(timeout), 0);
    #2 rst_n = 1'b1;
    model_reset();
    step(4'hA, 1'b0);
    check("post_areset_en", int'(en), 1);
    check("post_areset_sel", int'({sel1, sel0}), 1);
    step(4'hA, 1'b1);
    check("post_areset_gap_en", int'(en), 0);

    // Randomized traffic against the model.
    rr = 4'hF;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) rr = 4'($urandom_range(0, 15));
      dd = ($urandom_range(0, 5) == 0);
      step(rr, dd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_sel_arb.md
# rr_sel_arb

Four-channel round-robin arbiter that sits directly upstream of the 2-to-4 enable decoder. It turns four request lines into a registered 2-bit channel index (`sel1`,`sel0`) plus a grant enable (`en`), which wire straight onto the decoder's `in1`/`in0`/`en` inputs. Grants are bounded in length, separated by a mandatory idle gap, and rotated fairly, so the decoder's one-hot outputs never overlap.

## Interface

Parameters:
- `HOLD_MAX`, default 4: maximum consecutive cycles a single grant may stay asserted; legal range 1..255.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req`  in  4  per-channel request; level-sensitive.
- `done`  in  1  current grantee releases its grant; sampled only in GRANT.
- `sel0`  out  1  granted channel index, bit 0; drives decoder `in0`.
- `sel1`  out  1  granted channel index, bit 1; drives decoder `in1`.
- `en`  out  1  grant valid; drives decoder `en`.
- `timeout`  out  1  one-cycle pulse: the last grant was force-released by the hold limit.

## Operation

- States: IDLE, GRANT, GAP.
- Rotating pointer `ptr` (2 bits) holds the highest-priority channel. Priority order is `ptr`, `ptr+1`, `ptr+2`, `ptr+3`, all mod 4.
- **IDLE:** if `req != 0`, pick the first requesting channel in priority order, register it into {`sel1`,`sel0`}, load the hold counter `cnt` with 1, and go to GRANT. If `req == 0`, stay in IDLE; `sel` keeps its last value.
- **GRANT:** `en = 1` and `sel` is frozen. A release occurs at the clock edge when any of these holds:
  - `done = 1`
  - `req[sel] = 0`
  - `cnt == HOLD_MAX`
- **On release:** set `ptr <= sel + 1` (mod 4) and go to GAP. If there is no release, `cnt` increments.
- **GAP:** exactly one cycle with `en = 0`, then return to IDLE unconditionally.
- **`timeout`:** 1 during the GAP cycle only when the release was caused solely by `cnt == HOLD_MAX`. If `done` or a dropped request coincides with the limit, the release counts as normal and `timeout` stays 0.
- **Width:** `cnt` is 8 bits and never exceeds `HOLD_MAX`.

## Timing

- **Reset values:**
  - state = IDLE, `ptr` = 0, `cnt` = 0
  - `sel0` = 0, `sel1` = 0, `en` = 0, `timeout` = 0
- Reset acts immediately and asynchronously. If it arrives mid-grant, `en` drops with `rst_n` and no GAP cycle follows.
- **Request-to-grant latency:** a request seen in IDLE at edge N gives `en = 1` with valid `sel` after edge N; this is 1 cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- **Grant length:** `en` stays high for 1..`HOLD_MAX` cycles.
- **Minimum gap:** between two grants `en` is low for 2 cycles (GAP then IDLE). Back-to-back grants to the same channel are allowed only if no other channel is requesting.
- `sel` changes only on the edge that enters GRANT. It is stable for the whole `en` window and through GAP, so the decoder never sees a select glitch while enabled.
- Requests arriving during GRANT or GAP are not lost; being level-sensitive, they are arbitrated in the next IDLE.

## Structure

- **Shared package `rr_sel_pkg`:**
  - state enum {IDLE, GRANT, GAP}
  - `NUM_CH = 4`
  - `IDX_W = 2`
  - `CNT_W = 8`
- **Sub-module `rr_pick`:** combinational; inputs are `req[3:0]` and `ptr[1:0]`; outputs are `found` and `idx[1:0]`. It rotates `req` by `ptr`, applies a fixed priority encoder, and rotates the result back.
- The top level holds the FSM, `ptr`, `cnt`, and the output registers.

## Test plan

- **Reset:** assert `rst_n = 0` with `req = 4'b1111` → `en = 0`, `sel = 0`, `timeout = 0`. Release reset → one cycle later `en = 1`, `sel = 0`.
- **Rotation:** hold `req = 4'b1111`, pulse `done` in each grant's first cycle → granted `sel` sequence 0,1,2,3,0, with `en` low for 2 cycles between grants.
- **Timeout:** `req = 4'b0100` held, `done = 0`, `HOLD_MAX = 4` → `en` high exactly 4 cycles with `sel = 2`, then `timeout = 1` for one cycle, then re-grant to channel 2.
- **Coincident release:** `done = 1` on the cycle `cnt == HOLD_MAX` → release occurs and `timeout` stays 0.
- **Request drop:** channel 3 granted, `req[3]` deasserted mid-grant → GAP next cycle; `ptr` = 0, so the next grant goes to the lowest pending channel at or after 0.
- **Async reset mid-grant:** `rst_n` pulsed low between edges while `en = 1` → `en` = 0 immediately. After reset, arbitration restarts from `ptr = 0`.
